// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-of-day / alarm register bank.
//   mode_t   : synchronised controller mode (run, set minute, set hour, set alarm)
//   bcd2_t   : two-digit packed BCD value {tens, units}
//   BCD_59 / BCD_23 : wrap limits for minutes/seconds and hours
//   bcd_inc  : next BCD value with wrap to 00 at a given limit
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_MIN   = 2'b01,
    MODE_SET_HOUR  = 2'b10,
    MODE_SET_ALARM = 2'b11
  } mode_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_00 = 8'h00;
  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_23 = 8'h23;

  // Increment a two-digit BCD value, returning 00 when the limit is reached.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    if (v == max) begin
      r = BCD_00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// Two-digit BCD counter that wraps MAX -> 00.
//   clk     in   clock
//   reset_n in   asynchronous active-low reset (q -> 00)
//   inc     in   advance by one this cycle
//   clr     in   force to 00 (wins over inc)
//   q       out  current value
//   carry   out  inc while at MAX (combinational, same cycle as the wrap)
// -----------------------------------------------------------------------------
module bcd_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = BCD_59
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t q,
  output logic  carry
);

  bcd2_t r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= BCD_00;
    end else if (clr) begin
      r_q <= BCD_00;
    end else if (inc) begin
      r_q <= bcd_inc(r_q, MAX);
    end
  end

  assign q     = r_q;
  assign carry = inc & (r_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// Time-of-day (hh:mm:ss) and alarm (hh:mm) register bank in BCD, with an
// alarm flag that stays up for ALARM_SECS seconds after a match.
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   tick_1s      in   one-clock strobe per second (synchronous)
//   mod [1:0]    in   controller mode, asynchronous (synchronised here)
//   adj          in   debounced add key level, asynchronous (synchronised here)
//   sec_bcd      out  seconds 00..59
//   min_bcd      out  minutes 00..59
//   hour_bcd     out  hours 00..23
//   alm_min_bcd  out  alarm minutes 00..59
//   alm_hour_bcd out  alarm hours 00..23
//   alarm_on     out  alarm active flag
// -----------------------------------------------------------------------------
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned ALARM_SECS  = 30,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1s,
  input  logic [1:0] mod,
  input  logic       adj,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [7:0] alm_min_bcd,
  output logic [7:0] alm_hour_bcd,
  output logic       alarm_on
);

  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

  // ---------------------------------------------------------------------------
  // Input synchronisers and adj rising-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][1:0] r_mod_sync;
  logic [SYNC_STAGES-1:0]      r_adj_sync;
  logic                        r_adj_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mod_sync <= '0;
      r_adj_sync <= '0;
      r_adj_prev <= 1'b0;
    end else begin
      r_mod_sync <= {r_mod_sync[SYNC_STAGES-2:0], mod};
      r_adj_sync <= {r_adj_sync[SYNC_STAGES-2:0], adj};
      r_adj_prev <= r_adj_sync[SYNC_STAGES-1];
    end
  end

  mode_t w_mode;
  logic  w_adj_p;
  logic  w_run;
  logic  w_set_min;
  logic  w_set_hour;
  logic  w_set_alarm;

  assign w_mode      = mode_t'(r_mod_sync[SYNC_STAGES-1]);
  assign w_adj_p     = r_adj_sync[SYNC_STAGES-1] & ~r_adj_prev;
  assign w_run       = (w_mode == MODE_RUN);
  assign w_set_min   = (w_mode == MODE_SET_MIN);
  assign w_set_hour  = (w_mode == MODE_SET_HOUR);
  assign w_set_alarm = (w_mode == MODE_SET_ALARM);

  // ---------------------------------------------------------------------------
  // Mode steering of the five counters
  // ---------------------------------------------------------------------------
  bcd2_t w_sec_q, w_min_q, w_hour_q, w_alm_min_q, w_alm_hour_q;
  logic  w_sec_carry, w_min_carry, w_hour_carry, w_alm_min_carry, w_alm_hour_carry;
  logic  w_sec_inc, w_min_inc, w_hour_inc, w_alm_min_inc;

  // Seconds are held at 00 while setting minutes; they keep running otherwise.
  assign w_sec_inc = tick_1s & ~w_set_min;
  // While setting minutes the key drives them; their wrap does not reach hours.
  assign w_min_inc = w_set_min ? w_adj_p : w_sec_carry;
  // While setting hours any minute carry is discarded, so a coinciding key
  // press and rollover still advance the hour by exactly one.
  assign w_hour_inc    = w_set_hour ? w_adj_p : (w_min_carry & ~w_set_min);
  assign w_alm_min_inc = w_set_alarm & w_adj_p;

  bcd_counter #(.MAX(BCD_59)) u_sec (
    .clk(clk), .reset_n(reset_n), .inc(w_sec_inc), .clr(w_set_min),
    .q(w_sec_q), .carry(w_sec_carry)
  );

  bcd_counter #(.MAX(BCD_59)) u_min (
    .clk(clk), .reset_n(reset_n), .inc(w_min_inc), .clr(1'b0),
    .q(w_min_q), .carry(w_min_carry)
  );

  bcd_counter #(.MAX(BCD_23)) u_hour (
    .clk(clk), .reset_n(reset_n), .inc(w_hour_inc), .clr(1'b0),
    .q(w_hour_q), .carry(w_hour_carry)
  );

  bcd_counter #(.MAX(BCD_59)) u_alm_min (
    .clk(clk), .reset_n(reset_n), .inc(w_alm_min_inc), .clr(1'b0),
    .q(w_alm_min_q), .carry(w_alm_min_carry)
  );

  bcd_counter #(.MAX(BCD_23)) u_alm_hour (
    .clk(clk), .reset_n(reset_n), .inc(w_alm_min_carry), .clr(1'b0),
    .q(w_alm_hour_q), .carry(w_alm_hour_carry)
  );

  // Hours and alarm hours roll over silently; their carries go nowhere.
  logic w_unused_carry;
  assign w_unused_carry = w_hour_carry | w_alm_hour_carry;

  // ---------------------------------------------------------------------------
  // Alarm match: compare against the time this tick is about to produce, so
  // the flag rises on the same edge that shows hh:mm:00.
  // ---------------------------------------------------------------------------
  bcd2_t w_min_next, w_hour_next;
  logic  w_match;

  assign w_min_next  = w_sec_carry ? bcd_inc(w_min_q, BCD_59) : w_min_q;
  assign w_hour_next = w_min_carry ? bcd_inc(w_hour_q, BCD_23) : w_hour_q;
  assign w_match     = w_run & w_sec_carry
                     & (w_min_next == w_alm_min_q)
                     & (w_hour_next == w_alm_hour_q);

  // ---------------------------------------------------------------------------
  // Alarm flag and down-counter. Counter holds the number of ticks left; the
  // tick that would take it from 1 to 0 drops the flag.
  // ---------------------------------------------------------------------------
  logic       r_alarm_on;
  logic [7:0] r_alm_cnt;
  logic       w_expire;
  logic       w_clear;

  assign w_expire = r_alarm_on & tick_1s & (r_alm_cnt == 8'd1);
  // Any clear source wins over a match in the same cycle.
  assign w_clear  = w_expire | (w_run & w_adj_p) | ~w_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm_on <= 1'b0;
      r_alm_cnt  <= 8'd0;
    end else if (w_clear) begin
      r_alarm_on <= 1'b0;
      r_alm_cnt  <= 8'd0;
    end else if (w_match) begin
      r_alarm_on <= 1'b1;
      r_alm_cnt  <= ALARM_LOAD;
    end else if (r_alarm_on && tick_1s) begin
      r_alm_cnt  <= r_alm_cnt - 8'd1;
    end
  end

  assign sec_bcd      = w_sec_q;
  assign min_bcd      = w_min_q;
  assign hour_bcd     = w_hour_q;
  assign alm_min_bcd  = w_alm_min_q;
  assign alm_hour_bcd = w_alm_hour_q;
  assign alarm_on     = r_alarm_on;

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
// Directed bench for time_keeper: times and alarm settings are built up with
// key pulses and ticks, then checked against hand-computed BCD values.
// -----------------------------------------------------------------------------
module tb_time_keeper;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ALARM_SECS  = 30;

  logic       clk;
  logic       reset_n;
  logic       tick_1s;
  logic [1:0] mod;
  logic       adj;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic [7:0] alm_min_bcd;
  logic [7:0] alm_hour_bcd;
  logic       alarm_on;

  int errors = 0;
  int checks = 0;

  time_keeper #(
    .ALARM_SECS (ALARM_SECS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_1s     (tick_1s),
    .mod         (mod),
    .adj         (adj),
    .sec_bcd     (sec_bcd),
    .min_bcd     (min_bcd),
    .hour_bcd    (hour_bcd),
    .alm_min_bcd (alm_min_bcd),
    .alm_hour_bcd(alm_hour_bcd),
    .alarm_on    (alarm_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, "_hour"}, hour_bcd, h);
    chk({tag, "_min"},  min_bcd,  m);
    chk({tag, "_sec"},  sec_bcd,  s);
  endtask

  task automatic chk_alarm_regs(input string tag, input logic [7:0] h, input logic [7:0] m);
    chk({tag, "_alm_hour"}, alm_hour_bcd, h);
    chk({tag, "_alm_min"},  alm_min_bcd,  m);
  endtask

  task automatic chk_on(input string tag, input logic exp);
    chk(tag, {7'd0, alarm_on}, {7'd0, exp});
  endtask

  task automatic pulse_adj();
    @(posedge clk); #1 adj = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 adj = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse_adj();
  endtask

  task automatic tick();
    @(posedge clk); #1 tick_1s = 1'b1;
    @(posedge clk); #1 tick_1s = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(posedge clk); #1 mod = m;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    tick_1s = 1'b0;
    mod     = 2'b00;
    adj     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk_alarm_regs("reset", 8'h00, 8'h00);
    chk_on("reset_alarm_on", 1'b0);
    reset_n = 1'b1;
    $display("step reset: outputs checked while reset held");

    // Hour preset, then minute set mode with wrap and tick suppression.
    set_mode(2'b10);
    pulses(5);
    chk("sethour_5", hour_bcd, 8'h05);
    $display("step set hour: hour=%h", hour_bcd);

    set_mode(2'b01);
    pulses(59);
    chk("setmin_59", min_bcd, 8'h59);
    tick();
    chk("setmin_tick_sec_held", sec_bcd, 8'h00);
    pulse_adj();
    chk_time("setmin_wrap", 8'h05, 8'h00, 8'h00);
    $display("step set minute wrap: %h:%h:%h", hour_bcd, min_bcd, sec_bcd);

    // Build 23:59:58 then run through midnight (alarm at 00:00 matches).
    set_mode(2'b10);
    pulses(18);
    chk("sethour_23", hour_bcd, 8'h23);
    set_mode(2'b01);
    pulses(59);
    set_mode(2'b00);
    ticks(58);
    chk_time("run_235958", 8'h23, 8'h59, 8'h58);
    tick();
    chk_time("run_235959", 8'h23, 8'h59, 8'h59);
    chk_on("run_235959_alarm_off", 1'b0);
    tick();
    chk_time("run_midnight", 8'h00, 8'h00, 8'h00);
    chk_alarm_regs("run_midnight", 8'h00, 8'h00);
    chk_on("run_midnight_alarm_on", 1'b1);
    $display("step midnight rollover: %h:%h:%h alarm_on=%b", hour_bcd, min_bcd, sec_bcd, alarm_on);

    // Silence with the key in run mode; clear lands on edge SYNC_STAGES+1.
    @(posedge clk); #1 adj = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 chk_on("silence_before", 1'b1);
    @(posedge clk);
    #1 chk_on("silence_at_latency", 1'b0);
    adj = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    pulse_adj();
    chk_time("run_adj_noeffect", 8'h00, 8'h00, 8'h00);
    chk_on("run_adj_noeffect_alarm", 1'b0);
    $display("step silence: alarm_on=%b", alarm_on);

    // Hour set mode: key press coinciding with a minute rollover.
    set_mode(2'b10);
    pulses(23);
    chk("sethour_23b", hour_bcd, 8'h23);
    set_mode(2'b01);
    pulses(59);
    set_mode(2'b10);
    ticks(59);
    chk_time("sethour_235959", 8'h23, 8'h59, 8'h59);
    @(posedge clk); #1 adj = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 tick_1s = 1'b1;
    @(posedge clk);
    #1 tick_1s = 1'b0;
    chk_time("sethour_coincide", 8'h00, 8'h00, 8'h00);
    adj = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    $display("step hour set with carry: %h:%h:%h", hour_bcd, min_bcd, sec_bcd);

    // Alarm set 06:59 -> 07:00, then match and full duration.
    set_mode(2'b11);
    pulses(6 * 60 + 59);
    chk_alarm_regs("alarm_0659", 8'h06, 8'h59);
    pulse_adj();
    chk_alarm_regs("alarm_0700", 8'h07, 8'h00);
    set_mode(2'b10);
    pulses(6);
    set_mode(2'b01);
    pulses(59);
    set_mode(2'b00);
    ticks(59);
    chk_time("run_065959", 8'h06, 8'h59, 8'h59);
    chk_on("run_065959_alarm", 1'b0);
    tick();
    chk_time("match_0700", 8'h07, 8'h00, 8'h00);
    chk_on("match_0700_alarm", 1'b1);
    ticks(ALARM_SECS - 1);
    chk_on("alarm_last_tick_on", 1'b1);
    chk("alarm_last_tick_sec", sec_bcd, 8'h29);
    tick();
    chk_on("alarm_expired", 1'b0);
    chk("alarm_expired_sec", sec_bcd, 8'h30);
    $display("step alarm duration: %h:%h:%h alarm_on=%b", hour_bcd, min_bcd, sec_bcd, alarm_on);

    // Mode leaving run clears the flag; seconds survive the mode change.
    set_mode(2'b11);
    pulse_adj();
    chk_alarm_regs("alarm_0701", 8'h07, 8'h01);
    set_mode(2'b00);
    ticks(30);
    chk_time("match_0701", 8'h07, 8'h01, 8'h00);
    chk_on("match_0701_alarm", 1'b1);
    ticks(5);
    set_mode(2'b10);
    chk_on("modeleave_alarm", 1'b0);
    chk("modeleave_sec_kept", sec_bcd, 8'h05);
    $display("step mode leave: sec=%h alarm_on=%b", sec_bcd, alarm_on);

    // Retrigger at 07:02 then asynchronous reset mid-second.
    set_mode(2'b11);
    pulse_adj();
    set_mode(2'b00);
    ticks(55);
    chk_time("match_0702", 8'h07, 8'h02, 8'h00);
    chk_on("match_0702_alarm", 1'b1);
    ticks(3);
    chk("prereset_sec", sec_bcd, 8'h03);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_time("async_reset", 8'h00, 8'h00, 8'h00);
    chk_alarm_regs("async_reset", 8'h00, 8'h00);
    chk_on("async_reset_alarm", 1'b0);
    $display("step async reset: %h:%h:%h alarm_on=%b", hour_bcd, min_bcd, sec_bcd, alarm_on);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
